// File: rtl/decimal_adjust_unit_pkg.sv
// Shared dataflow definitions for the adder hold / decimal adjust stage.
// Holds the BCD correction constants and the packed record of a captured ALU operation.
package decimal_adjust_unit_pkg;

  localparam logic [7:0] BCD_LOW_FIX    = 8'h06;
  localparam logic [7:0] BCD_HIGH_FIX   = 8'h60;
  localparam logic [3:0] BCD_NIBBLE_MAX = 4'd9;
  localparam logic [7:0] BCD_BYTE_MAX   = 8'h99;

  typedef struct packed {
    logic [7:0] raw;
    logic       carry;
    logic       half;
    logic       decimal;
    logic       sub;
  } held_op_t;

endpackage

// File: rtl/decimal_adjust_unit_if.sv
// Capture/handshake bundle between the ALU, the accumulator and the adder hold stage.
interface decimal_adjust_unit_if;

  logic       adderHoldLoad;
  logic [7:0] aluResult;
  logic       aluCarryOut;
  logic       aluHalfCarry;
  logic       decimalMode;
  logic       isSubtract;
  logic       accumulatorReadAck;
  logic       stackBusWriteEnable;
  logic       addressBusLowWriteEnable;
  logic [7:0] outputFromDecimalAdjust;
  logic       adjustedCarry;
  logic       adjustValid;

  modport master (
    output adderHoldLoad, aluResult, aluCarryOut, aluHalfCarry, decimalMode, isSubtract,
    output accumulatorReadAck, stackBusWriteEnable, addressBusLowWriteEnable,
    input  outputFromDecimalAdjust, adjustedCarry, adjustValid
  );

  modport slave (
    input  adderHoldLoad, aluResult, aluCarryOut, aluHalfCarry, decimalMode, isSubtract,
    input  accumulatorReadAck, stackBusWriteEnable, addressBusLowWriteEnable,
    output outputFromDecimalAdjust, adjustedCarry, adjustValid
  );

endinterface

// File: rtl/decimal_adjust_unit_bcd_correction_logic.sv
// Purely combinational BCD correction of a held ALU result.
// Binary ops pass through; decimal add/subtract apply the 06/60 nibble fixes.
module bcd_correction_logic
  import decimal_adjust_unit_pkg::*;
(
  input  held_op_t   held_i,
  output logic [7:0] corrected_o,
  output logic       carry_o
);

  logic       low_fix;
  logic       high_fix;
  logic [7:0] low_amt;
  logic [7:0] high_amt;

  always_comb begin
    low_fix     = 1'b0;
    high_fix    = 1'b0;
    corrected_o = held_i.raw;
    carry_o     = held_i.carry;

    if (held_i.decimal) begin
      if (held_i.sub) begin
        // Subtract flags mean "no borrow", so a fix is needed when they are clear.
        low_fix  = ~held_i.half;
        high_fix = ~held_i.carry;
      end else begin
        low_fix  = held_i.half  | (held_i.raw[3:0] > BCD_NIBBLE_MAX);
        high_fix = held_i.carry | (held_i.raw > BCD_BYTE_MAX);
      end
    end

    low_amt  = low_fix  ? BCD_LOW_FIX  : 8'h00;
    high_amt = high_fix ? BCD_HIGH_FIX : 8'h00;

    if (held_i.decimal) begin
      if (held_i.sub) begin
        corrected_o = held_i.raw - low_amt - high_amt;
        carry_o     = held_i.carry;
      end else begin
        corrected_o = held_i.raw + low_amt + high_amt;
        carry_o     = high_fix;
      end
    end
  end

endmodule

// File: rtl/decimal_adjust_unit.sv
// Adder hold stage: captures the ALU result with its flags and mode, presents the
// BCD-corrected byte to the accumulator and drives the raw value onto SB / ABL.
module decimal_adjust_unit
  import decimal_adjust_unit_pkg::*;
#(
  parameter logic [7:0] defaultValue = 8'h00
) (
  input  logic                  clk,
  input  logic                  nrst,
  decimal_adjust_unit_if.slave  bus_if,
  output wire  [7:0]            stackBusOutput,
  output wire  [7:0]            addressBusLowOutput
);

  held_op_t held_q, held_d;
  logic     valid_q, valid_d;

  always_comb begin
    held_d  = held_q;
    valid_d = valid_q;
    if (bus_if.adderHoldLoad) begin
      // Mode bits travel with the data so a later D-flag change cannot alter the result.
      held_d.raw     = bus_if.aluResult;
      held_d.carry   = bus_if.aluCarryOut;
      held_d.half    = bus_if.aluHalfCarry;
      held_d.decimal = bus_if.decimalMode;
      held_d.sub     = bus_if.isSubtract;
      valid_d        = 1'b1;
    end else if (bus_if.accumulatorReadAck) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      held_q.raw     <= defaultValue;
      held_q.carry   <= 1'b0;
      held_q.half    <= 1'b0;
      held_q.decimal <= 1'b0;
      held_q.sub     <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      held_q  <= held_d;
      valid_q <= valid_d;
    end
  end

  bcd_correction_logic u_bcd (
    .held_i      (held_q),
    .corrected_o (bus_if.outputFromDecimalAdjust),
    .carry_o     (bus_if.adjustedCarry)
  );

  assign bus_if.adjustValid = valid_q;

  assign stackBusOutput      = bus_if.stackBusWriteEnable      ? held_q.raw : 8'hzz;
  assign addressBusLowOutput = bus_if.addressBusLowWriteEnable ? held_q.raw : 8'hzz;

endmodule

// File: tb/tb_decimal_adjust_unit.sv
// Self-checking bench for decimal_adjust_unit: vector table through a scoreboard
// queue, plus hand-written handshake, mode-sampling, bus and reset sequences.
module tb_decimal_adjust_unit;

  localparam logic [7:0] DEF_VAL = 8'h5A;

  logic clk;
  logic nrst;
  wire  [7:0] sb_out;
  wire  [7:0] abl_out;

  decimal_adjust_unit_if dut_if ();

  decimal_adjust_unit #(.defaultValue(DEF_VAL)) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .bus_if              (dut_if),
    .stackBusOutput      (sb_out),
    .addressBusLowOutput (abl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] raw;
    logic       c;
    logic       h;
    logic       d;
    logic       sub;
    logic [7:0] exp_out;
    logic       exp_c;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       c;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Released bus: must not carry the held raw value (raw chosen non-zero).
  task automatic chk_released(input string name, input logic [7:0] act, input logic [7:0] raw);
    checks++;
    if (act === raw) begin
      errors++;
      $display("FAIL %s actual=%h required=released(not %h)", name, act, raw);
    end else begin
      $display("ok   %s released value=%h", name, act);
    end
  endtask

  task automatic idle_inputs();
    dut_if.adderHoldLoad            = 1'b0;
    dut_if.aluResult                = 8'h00;
    dut_if.aluCarryOut              = 1'b0;
    dut_if.aluHalfCarry             = 1'b0;
    dut_if.decimalMode              = 1'b0;
    dut_if.isSubtract               = 1'b0;
    dut_if.accumulatorReadAck       = 1'b0;
    dut_if.stackBusWriteEnable      = 1'b0;
    dut_if.addressBusLowWriteEnable = 1'b0;
  endtask

  // Drive one load on the next edge, push its expectation, then compare after the edge.
  task automatic load_and_check(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    dut_if.aluResult     = v.raw;
    dut_if.aluCarryOut   = v.c;
    dut_if.aluHalfCarry  = v.h;
    dut_if.decimalMode   = v.d;
    dut_if.isSubtract    = v.sub;
    dut_if.adderHoldLoad = 1'b1;
    e.out = v.exp_out;
    e.c   = v.exp_c;
    sb_q.push_back(e);
    @(negedge clk);
    dut_if.adderHoldLoad = 1'b0;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty vec%0d actual=0 required=1", idx);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("vec%0d_out", idx), dut_if.outputFromDecimalAdjust, e.out);
      chk($sformatf("vec%0d_carry", idx), {7'd0, dut_if.adjustedCarry}, {7'd0, e.c});
      chk($sformatf("vec%0d_valid", idx), {7'd0, dut_if.adjustValid}, 8'd1);
    end
  endtask

  initial begin
    //            raw    c     h     d     sub   out    carry
    vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42, 1'b0};
    vecs[1] = '{8'h9A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 8'h09, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 1'b0};
    vecs[4] = '{8'h9A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h9A, 1'b1};
    vecs[5] = '{8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h16, 1'b0};
    vecs[6] = '{8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 8'h65, 1'b1};
    vecs[7] = '{8'h42, 1'b1, 1'b1, 1'b1, 1'b1, 8'h42, 1'b1};
    vecs[8] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 1'b1};

    idle_inputs();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out", dut_if.outputFromDecimalAdjust, DEF_VAL);
    chk("reset_carry", {7'd0, dut_if.adjustedCarry}, 8'd0);
    chk("reset_valid", {7'd0, dut_if.adjustValid}, 8'd0);
    chk_released("reset_sb", sb_out, DEF_VAL);
    chk_released("reset_abl", abl_out, DEF_VAL);
    nrst = 1'b1;
    @(negedge clk);
    dut_if.stackBusWriteEnable = 1'b1;
    #1;
    chk("reset_raw_on_sb", sb_out, DEF_VAL);
    dut_if.stackBusWriteEnable = 1'b0;

    for (int i = 0; i < 9; i++) load_and_check(vecs[i], i);

    // Binary load, then flip the mode inputs and the ALU bus without loading.
    load_and_check('{8'h9A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h9A, 1'b0}, 9);
    dut_if.decimalMode = 1'b1;
    dut_if.isSubtract  = 1'b1;
    dut_if.aluResult   = 8'h11;
    @(negedge clk);
    chk("mode_toggle_out", dut_if.outputFromDecimalAdjust, 8'h9A);
    chk("mode_toggle_carry", {7'd0, dut_if.adjustedCarry}, 8'd0);

    // Ack without load clears valid.
    dut_if.accumulatorReadAck = 1'b1;
    @(negedge clk);
    dut_if.accumulatorReadAck = 1'b0;
    chk("ack_clears_valid", {7'd0, dut_if.adjustValid}, 8'd0);
    chk("ack_keeps_out", dut_if.outputFromDecimalAdjust, 8'h9A);

    // Load and ack on the same edge: load wins.
    dut_if.aluResult          = 8'h3C;
    dut_if.aluCarryOut        = 1'b0;
    dut_if.aluHalfCarry       = 1'b0;
    dut_if.decimalMode        = 1'b1;
    dut_if.isSubtract         = 1'b0;
    dut_if.adderHoldLoad      = 1'b1;
    dut_if.accumulatorReadAck = 1'b1;
    @(negedge clk);
    dut_if.adderHoldLoad      = 1'b0;
    dut_if.accumulatorReadAck = 1'b0;
    chk("load_ack_valid", {7'd0, dut_if.adjustValid}, 8'd1);
    chk("load_ack_out", dut_if.outputFromDecimalAdjust, 8'h42);

    // Buses carry raw (3C), not the adjusted 42.
    dut_if.stackBusWriteEnable = 1'b1;
    #1;
    chk("sb_only_sb", sb_out, 8'h3C);
    chk_released("sb_only_abl", abl_out, 8'h3C);
    dut_if.addressBusLowWriteEnable = 1'b1;
    #1;
    chk("both_sb", sb_out, 8'h3C);
    chk("both_abl", abl_out, 8'h3C);
    dut_if.stackBusWriteEnable = 1'b0;
    #1;
    chk_released("abl_only_sb", sb_out, 8'h3C);
    chk("abl_only_abl", abl_out, 8'h3C);
    dut_if.addressBusLowWriteEnable = 1'b0;

    // Asynchronous reset mid-cycle discards the pending result.
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_out", dut_if.outputFromDecimalAdjust, DEF_VAL);
    chk("async_rst_carry", {7'd0, dut_if.adjustedCarry}, 8'd0);
    chk("async_rst_valid", {7'd0, dut_if.adjustValid}, 8'd0);
    chk_released("async_rst_sb", sb_out, 8'h3C);
    chk_released("async_rst_abl", abl_out, 8'h3C);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
